// File: rtl/mem_dump_reader.sv
// mem_dump_reader: reads a contiguous byte range from a synchronous-read
// memory port, one read in flight at a time, and streams each byte out as an
// {address, data} pair. Every output is driven straight from a flop.
//
// Stream handshake: a pair transfers on any rising clk edge where out_valid
// and out_ready are both high. Once out_valid rises, out_valid, out_addr and
// out_data hold steady until that transfer edge (or until abort/reset).
// out_ready may be high or low at any time and has no effect without out_valid.
module mem_dump_reader #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Latency counter is loaded with MEM_LAT (1 or 2) and counts down to 1.
  localparam logic [1:0]        LAT_INIT = 2'(MEM_LAT);
  localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nx;
  logic [ADDR_W-1:0] rem, rem_nx;
  logic [1:0]        lat, lat_nx;
  logic              busy_nx, done_nx, rd_en_nx, valid_nx;
  logic [ADDR_W-1:0] mem_addr_nx, out_addr_nx;
  logic [DATA_W-1:0] out_data_nx;

  assign fsm_state = state;

  // State and registered outputs; reset clears everything with no done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      rem       <= '0;
      lat       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_nx;
      cur_addr  <= cur_addr_nx;
      rem       <= rem_nx;
      lat       <= lat_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      mem_rd_en <= rd_en_nx;
      mem_addr  <= mem_addr_nx;
      out_valid <= valid_nx;
      out_addr  <= out_addr_nx;
      out_data  <= out_data_nx;
    end
  end

  // Next-state and next-output logic; the read strobe is computed one cycle
  // ahead so that it is high exactly for the cycle spent in REQ.
  always_comb begin
    state_nx    = state;
    cur_addr_nx = cur_addr;
    rem_nx      = rem;
    lat_nx      = lat;
    busy_nx     = busy;
    done_nx     = 1'b0;
    rd_en_nx    = 1'b0;
    mem_addr_nx = mem_addr;
    valid_nx    = out_valid;
    out_addr_nx = out_addr;
    out_data_nx = out_data;

    case (state)
      IDLE: begin
        busy_nx  = 1'b0;
        valid_nx = 1'b0;
        if (start) begin
          if (count != '0) begin
            cur_addr_nx = start_addr;
            rem_nx      = count;
            busy_nx     = 1'b1;
            rd_en_nx    = 1'b1;
            mem_addr_nx = start_addr;
            state_nx    = REQ;
          end else begin
            // Empty range: acknowledge immediately without reading.
            done_nx = 1'b1;
          end
        end
      end

      REQ: begin
        // mem_rd_en is high during this cycle and drops at the next edge.
        lat_nx   = LAT_INIT;
        state_nx = WAIT;
      end

      WAIT: begin
        if (lat == 2'd1) begin
          out_data_nx = mem_rd_data;
          out_addr_nx = cur_addr;
          valid_nx    = 1'b1;
          lat_nx      = 2'd0;
          state_nx    = HOLD;
        end else begin
          lat_nx = lat - 2'd1;
        end
      end

      HOLD: begin
        if (out_ready) begin
          valid_nx = 1'b0;
          if (rem == ONE) begin
            rem_nx   = '0;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
          end else begin
            // Address wraps naturally at 2^ADDR_W.
            rem_nx      = rem - ONE;
            cur_addr_nx = cur_addr + ONE;
            mem_addr_nx = cur_addr + ONE;
            rd_en_nx    = 1'b1;
            state_nx    = REQ;
          end
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE, including a concurrent
    // handshake (that pair still counts as consumed by the consumer).
    if (state != IDLE && abort) begin
      state_nx = IDLE;
      busy_nx  = 1'b0;
      valid_nx = 1'b0;
      rd_en_nx = 1'b0;
      done_nx  = 1'b0;
      lat_nx   = 2'd0;
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: one instance with MEM_LAT=1 and one with
// MEM_LAT=2, each fed by its own synchronous-read memory model.
module tb_mem_dump_reader;

  localparam int AW = 16;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          start_i    [2];
  logic [AW-1:0] start_addr;
  logic [AW-1:0] count;
  logic          abort;
  logic          out_ready;
  logic          busy_o     [2];
  logic          done_o     [2];
  logic          rd_en_o    [2];
  logic          valid_o    [2];
  logic [AW-1:0] mem_addr_o [2];
  logic [AW-1:0] out_addr_o [2];
  logic [DW-1:0] out_data_o [2];
  logic [DW-1:0] rd_data    [2];
  logic [1:0]    state_o    [2];

  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] stage2;

  mem_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_i[0]), .start_addr(start_addr),
    .count(count), .abort(abort), .busy(busy_o[0]), .done(done_o[0]),
    .mem_rd_en(rd_en_o[0]), .mem_addr(mem_addr_o[0]), .mem_rd_data(rd_data[0]),
    .out_valid(valid_o[0]), .out_ready(out_ready), .out_addr(out_addr_o[0]),
    .out_data(out_data_o[0]), .fsm_state(state_o[0])
  );

  mem_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start_i[1]), .start_addr(start_addr),
    .count(count), .abort(abort), .busy(busy_o[1]), .done(done_o[1]),
    .mem_rd_en(rd_en_o[1]), .mem_addr(mem_addr_o[1]), .mem_rd_data(rd_data[1]),
    .out_valid(valid_o[1]), .out_ready(out_ready), .out_addr(out_addr_o[1]),
    .out_data(out_data_o[1]), .fsm_state(state_o[1])
  );

  // Synchronous-read memories: one-edge and two-edge read latency.
  always @(posedge clk) begin
    if (rd_en_o[0]) rd_data[0] <= mem[mem_addr_o[0]];
    if (rd_en_o[1]) stage2 <= mem[mem_addr_o[1]];
    rd_data[1] <= stage2;
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transfer-level view: a transfer owns a next address and a number of
  // bytes left; each byte becomes visible MEM_LAT+1 edges after it is
  // requested and is consumed by a handshake.
  bit            m_busy  [2];
  bit            m_done  [2];
  bit            m_rd    [2];
  bit            m_valid [2];
  logic [AW-1:0] m_addr  [2];
  int            m_rem   [2];
  int            m_wait  [2];

  // Model advance on each edge, cleared asynchronously by reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i]  <= 1'b0;
        m_done[i]  <= 1'b0;
        m_rd[i]    <= 1'b0;
        m_valid[i] <= 1'b0;
        m_addr[i]  <= '0;
        m_rem[i]   <= 0;
        m_wait[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] <= 1'b0;
        if (!m_busy[i]) begin
          if (start_i[i]) begin
            if (count != 0) begin
              m_busy[i] <= 1'b1;
              m_addr[i] <= start_addr;
              m_rem[i]  <= int'(count);
              m_wait[i] <= (i == 0) ? 2 : 3;
              m_rd[i]   <= 1'b1;
            end else begin
              m_done[i] <= 1'b1;
            end
          end
        end else if (abort) begin
          m_busy[i]  <= 1'b0;
          m_valid[i] <= 1'b0;
          m_rd[i]    <= 1'b0;
          m_wait[i]  <= 0;
        end else if (m_valid[i]) begin
          if (out_ready) begin
            m_valid[i] <= 1'b0;
            if (m_rem[i] == 1) begin
              m_busy[i] <= 1'b0;
              m_done[i] <= 1'b1;
            end else begin
              m_rem[i]  <= m_rem[i] - 1;
              m_addr[i] <= m_addr[i] + 16'd1;
              m_wait[i] <= (i == 0) ? 2 : 3;
              m_rd[i]   <= 1'b1;
            end
          end
        end else begin
          m_rd[i] <= 1'b0;
          if (m_wait[i] == 1) m_valid[i] <= 1'b1;
          m_wait[i] <= m_wait[i] - 1;
        end
      end
    end
  end

  // ---------------- handshake log ----------------
  logic [23:0] hs_pair   [2][64];
  int          hs_cyc    [2][64];
  int          hs_n      [2];
  int          start_cyc [2];
  int          cyc;
  int          done_cnt  [2];
  int          rd_cnt    [2];

  // Record every accepted pair with its edge number, and accepted starts.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (!rst && valid_o[i] && out_ready && hs_n[i] < 64) begin
        hs_pair[i][hs_n[i]] <= {out_addr_o[i], out_data_o[i]};
        hs_cyc[i][hs_n[i]]  <= cyc + 1;
        hs_n[i]             <= hs_n[i] + 1;
      end
      if (!rst && start_i[i] && !busy_o[i]) start_cyc[i] <= cyc + 1;
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check("busy", i, 32'(busy_o[i]), 32'(m_busy[i]));
      check("done", i, 32'(done_o[i]), 32'(m_done[i]));
      check("mem_rd_en", i, 32'(rd_en_o[i]), 32'(m_rd[i]));
      check("out_valid", i, 32'(valid_o[i]), 32'(m_valid[i]));
      if (m_rd[i]) check("mem_addr", i, 32'(mem_addr_o[i]), 32'(m_addr[i]));
      if (m_valid[i]) begin
        check("out_addr", i, 32'(out_addr_o[i]), 32'(m_addr[i]));
        check("out_data", i, 32'(out_data_o[i]), 32'(mem[m_addr[i]]));
      end
      if (done_o[i]) done_cnt[i]++;
      if (rd_en_o[i]) rd_cnt[i]++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int i, input logic [AW-1:0] a, input logic [AW-1:0] c);
    @(negedge clk);
    start_addr = a;
    count      = c;
    start_i[i] = 1'b1;
    @(negedge clk);
    start_i[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int limit, input string name);
    int n = 0;
    while (!done_o[i] && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, i, 32'(done_o[i]), 32'd1);
  endtask

  task automatic check_pairs(input int i, input int base, input string name, input int n,
                             input logic [23:0] e [8], input int gap, input int first);
    check({name, "_pairs"}, i, 32'(hs_n[i] - base), 32'(n));
    for (int k = 0; k < n; k++) begin
      check({name, "_pair"}, k, 32'(hs_pair[i][base + k]), 32'(e[k]));
      if (gap > 0 && k > 0)
        check({name, "_gap"}, k, 32'(hs_cyc[i][base + k] - hs_cyc[i][base + k - 1]), 32'(gap));
    end
    if (first > 0)
      check({name, "_first"}, i, 32'(hs_cyc[i][base] - start_cyc[i]), 32'(first));
  endtask

  // Hand-computed expected listings.
  logic [23:0] e_basic [8] = '{24'h000001, 24'h000102, 24'h000203, 24'h000304,
                               24'h000405, 24'h00050F, 24'h0, 24'h0};
  logic [23:0] e_wrap  [8] = '{24'hFFFFAA, 24'h0000BB, 24'h0, 24'h0,
                               24'h0, 24'h0, 24'h0, 24'h0};
  logic [23:0] e_bp    [8] = '{24'h001EAA, 24'h001FBB, 24'h0, 24'h0,
                               24'h0, 24'h0, 24'h0, 24'h0};

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int d0;
    int r0;
    int n;

    for (int a = 0; a < 65536; a++) mem[a] = '0;
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    mem[3] = 8'h04; mem[4] = 8'h05; mem[5] = 8'h0F;
    mem[16'hFFFF] = 8'hAA;
    mem[16'h001E] = 8'hAA;
    mem[16'h001F] = 8'hBB;
    for (int i = 0; i < 2; i++) begin
      hs_n[i] = 0; start_cyc[i] = 0; done_cnt[i] = 0; rd_cnt[i] = 0;
      start_i[i] = 1'b0;
    end
    cyc = 0;
    rst = 1'b1; start_addr = '0; count = '0; abort = 1'b0; out_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", i, 32'(busy_o[i]), 32'd0);
      check("rst_valid", i, 32'(valid_o[i]), 32'd0);
      check("rst_rd_en", i, 32'(rd_en_o[i]), 32'd0);
      check("rst_out_addr", i, 32'(out_addr_o[i]), 32'd0);
      check("rst_out_data", i, 32'(out_data_o[i]), 32'd0);
    end
    #2 rst = 1'b0;

    // Basic six-byte dump, MEM_LAT=1.
    base = hs_n[0]; d0 = done_cnt[0];
    pulse_start(0, 16'h0000, 16'd6);
    wait_done(0, 40, "basic");
    repeat (2) @(negedge clk);
    #1;
    check_pairs(0, base, "basic", 6, e_basic, 3, 3);
    check("basic_done_count", 0, 32'(done_cnt[0] - d0), 32'd1);
    check("basic_busy_after", 0, 32'(busy_o[0]), 32'd0);

    // Wrapping range FFFF -> 0000.
    mem[0] = 8'hBB;
    base = hs_n[0];
    pulse_start(0, 16'hFFFF, 16'd2);
    wait_done(0, 30, "wrap");
    @(negedge clk);
    mem[0] = 8'h01;
    check_pairs(0, base, "wrap", 2, e_wrap, 3, 3);

    // Backpressure: consumer stalls for 5 cycles on the first pair.
    base = hs_n[0];
    out_ready = 1'b0;
    pulse_start(0, 16'h001E, 16'd2);
    n = 0;
    while (!valid_o[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", 0, 32'(valid_o[0]), 32'd1);
    r0 = rd_cnt[0];
    repeat (5) begin
      check("bp_hold_addr", 0, 32'(out_addr_o[0]), 32'h001E);
      check("bp_hold_data", 0, 32'(out_data_o[0]), 32'hAA);
      @(negedge clk);
    end
    #1;
    check("bp_no_read", 0, 32'(rd_cnt[0] - r0), 32'd0);
    out_ready = 1'b1;
    wait_done(0, 30, "bp");
    @(negedge clk);
    check_pairs(0, base, "bp", 2, e_bp, 0, 0);

    // Empty range.
    base = hs_n[0]; d0 = done_cnt[0]; r0 = rd_cnt[0];
    pulse_start(0, 16'h0010, 16'd0);
    check("zero_done_hi", 0, 32'(done_o[0]), 32'd1);
    check("zero_busy", 0, 32'(busy_o[0]), 32'd0);
    @(negedge clk);
    check("zero_done_lo", 0, 32'(done_o[0]), 32'd0);
    repeat (4) @(negedge clk);
    #1;
    check("zero_done_count", 0, 32'(done_cnt[0] - d0), 32'd1);
    check("zero_no_read", 0, 32'(rd_cnt[0] - r0), 32'd0);
    check("zero_no_pairs", 0, 32'(hs_n[0] - base), 32'd0);

    // Start while busy is ignored.
    base = hs_n[0];
    pulse_start(0, 16'h0000, 16'd6);
    repeat (4) @(negedge clk);
    pulse_start(0, 16'h0100, 16'd3);
    wait_done(0, 40, "ign");
    @(negedge clk);
    check_pairs(0, base, "ign", 6, e_basic, 3, 3);

    // Abort after the second pair.
    base = hs_n[0];
    pulse_start(0, 16'h0000, 16'd6);
    n = 0;
    while (hs_n[0] - base < 2 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("abort_two_pairs", 0, 32'(hs_n[0] - base), 32'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 0, 32'(busy_o[0]), 32'd0);
    check("abort_valid", 0, 32'(valid_o[0]), 32'd0);
    check("abort_rd_en", 0, 32'(rd_en_o[0]), 32'd0);
    d0 = done_cnt[0];
    repeat (10) @(negedge clk);
    #1;
    check("abort_no_more", 0, 32'(hs_n[0] - base), 32'd2);
    check("abort_no_done", 0, 32'(done_cnt[0] - d0), 32'd0);

    // Same dump with MEM_LAT=2.
    base = hs_n[1]; d0 = done_cnt[1];
    pulse_start(1, 16'h0000, 16'd6);
    wait_done(1, 60, "lat2");
    repeat (2) @(negedge clk);
    #1;
    check_pairs(1, base, "lat2", 6, e_basic, 4, 4);
    check("lat2_done_count", 1, 32'(done_cnt[1] - d0), 32'd1);

    // Asynchronous reset while waiting on a read, then a fresh dump.
    pulse_start(0, 16'h0003, 16'd4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 0, 32'(busy_o[0]), 32'd0);
    check("arst_valid", 0, 32'(valid_o[0]), 32'd0);
    check("arst_done", 0, 32'(done_o[0]), 32'd0);
    check("arst_rd_en", 0, 32'(rd_en_o[0]), 32'd0);
    check("arst_mem_addr", 0, 32'(mem_addr_o[0]), 32'd0);
    check("arst_out_addr", 0, 32'(out_addr_o[0]), 32'd0);
    check("arst_out_data", 0, 32'(out_data_o[0]), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    base = hs_n[0];
    pulse_start(0, 16'h0000, 16'd2);
    wait_done(0, 30, "fresh");
    @(negedge clk);
    check_pairs(0, base, "fresh", 2, e_basic, 3, 3);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
- Read-back engine for CPU memory: the read-side counterpart to the listing loaders that write address/data pairs into memory.
- On a start command it reads a contiguous range of the shared byte memory through a synchronous-read port.
- It emits each byte as an {address, data} pair on a valid/ready stream.
- Benches and the debug path use it to dump result regions, e.g. the sum written at 0x0005, and compare them against expected listings.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory data width.
- MEM_LAT, 1, memory read latency in clock edges, from the edge that samples mem_rd_en to the edge at which mem_rd_data is valid for capture. Legal values are 1 and 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle command strobe.
- start_addr  in  ADDR_W  first address to read.
- count  in  ADDR_W  number of bytes to read; 0 means none.
- abort  in  1  synchronous cancel.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse when the last pair handshakes.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_rd_data  in  DATA_W  memory read data.
- out_valid  out  1  pair available.
- out_ready  in  1  consumer accepts the pair.
- out_addr  out  ADDR_W  address of the emitted byte.
- out_data  out  DATA_W  emitted byte.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, mem_rd_en, out_valid = 0; mem_addr, out_addr, out_data, internal addr/remaining/latency counters = 0. Takes effect mid-transfer with no done pulse.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - start=1 and count!=0: latch cur_addr=start_addr and rem=count, then go to REQ.
  - start=1 and count=0: done=1 for the next cycle only; stay in IDLE; busy stays 0.
- REQ: mem_rd_en=1 and mem_addr=cur_addr for exactly one cycle; load lat counter=MEM_LAT; go to WAIT.
- WAIT: count down. At the edge MEM_LAT after the edge that sampled mem_rd_en:
  - capture out_data=mem_rd_data and out_addr=cur_addr;
  - set out_valid=1;
  - go to HOLD.
- HOLD:
  - out_valid, out_addr and out_data stay stable while out_ready=0.
  - On an edge with out_valid & out_ready: out_valid drops to 0; rem decrements.
  - If rem was 1: done=1 for one cycle, go to IDLE.
  - Otherwise: cur_addr+1 modulo 2^ADDR_W (0xFFFF wraps to 0x0000), go to REQ.
- Latency:
  - First out_valid is visible in the cycle after edge E0+1+MEM_LAT, where E0 samples start.
  - With out_ready held high, consecutive handshakes are MEM_LAT+2 edges apart (3 for MEM_LAT=1).
  - done coincides with the cycle after the final handshake.
- Only one read is outstanding at a time; mem_rd_en is never asserted outside REQ.
- start while busy is ignored: no relatch, no effect on the current transfer.
- abort:
  - Sampled in any non-IDLE state, it forces IDLE at the next edge.
  - out_valid, mem_rd_en and busy clear, and no done pulse is produced.
  - An abort concurrent with a handshake edge still cancels; that pair counts as consumed.
  - abort is ignored in IDLE.
- Simultaneous start and abort in IDLE: start wins.
- count=0xFFFF reads 65535 bytes. A wrapped range continues from 0x0000.

Test Plan:
- Memory preset 0000..0005 = 01,02,03,04,05,0F. Start with start_addr=0x0000, count=6, out_ready=1, MEM_LAT=1 -> pairs (0000,01) (0001,02) (0002,03) (0003,04) (0004,05) (0005,0F) are emitted 3 edges apart. First out_valid appears 2 edges after start. done pulses once after the sixth pair, and busy then drops.
- Start with start_addr=0xFFFF, count=2, memory FFFF=AA, 0000=BB -> pairs (FFFF,AA) then (0000,BB); done pulses.
- Backpressure: start_addr=0x001E, count=2, out_ready held 0 for 5 cycles after first valid -> (001E,AA) is held stable with no new mem_rd_en. After out_ready rises, (001F,BB) follows; done pulses.
- Start with count=0 -> no mem_rd_en, no out_valid; done is high for exactly 1 cycle; busy stays 0.
- Mid-transfer events on a count=6 dump:
  - start pulse with a different start_addr during the transfer -> ignored; original sequence completes.
  - abort after the 2nd pair -> out_valid 0 and busy 0 the next cycle; no done pulse.
- Repeat the first scenario with MEM_LAT=2 -> identical data; handshakes 4 edges apart.
- Reset pulse while in WAIT -> all outputs 0 immediately (asynchronous); a fresh start then works normally.
